// File: rtl/iod_clk_delay_train_ctrl_if.sv
// Delay-line training port bundle: training control, eye/range status in,
// delay-line step commands and training results out.
interface iod_clk_delay_train_ctrl_if #(
    parameter int TAP_W = 8
);
    logic             start;
    logic             eye_ok;
    logic             delay_line_out_of_range;
    logic             delay_line_dir;
    logic             delay_line_move;
    logic             delay_line_load;
    logic             busy;
    logic             done;
    logic             fail;
    logic [TAP_W-1:0] tap_val;
    logic [TAP_W-1:0] eye_start;
    logic [TAP_W-1:0] eye_width;

    // master requests training and reports eye/range status; slave is the trainer
    modport master (
        output start, eye_ok, delay_line_out_of_range,
        input  delay_line_dir, delay_line_move, delay_line_load,
        input  busy, done, fail, tap_val, eye_start, eye_width
    );

    modport slave (
        input  start, eye_ok, delay_line_out_of_range,
        output delay_line_dir, delay_line_move, delay_line_load,
        output busy, done, fail, tap_val, eye_start, eye_width
    );
endinterface

// File: rtl/iod_clk_delay_train_ctrl.sv
// RX IO clock delay trainer: sweeps every tap, scores it with EYE_OK and parks
// the delay line at the centre of the widest fully-passing window.
module iod_clk_delay_train_ctrl #(
    parameter int NUM_TAPS      = 128,
    parameter int TAP_W         = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 32,
    parameter int MIN_EYE       = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    iod_clk_delay_train_ctrl_if.slave bus,
    output logic [3:0]                dbg_state_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL,
        S_STEP_UP, S_DECIDE, S_STEP_DN, S_DONE, S_FAIL
    } state_e;

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);
    localparam logic [TAP_W-1:0] MIN_W       = TAP_W'(MIN_EYE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       step_q, step_d;
    logic             pass_q, pass_d;
    logic             oor_q, oor_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] run_start_q, run_start_d;
    logic [TAP_W-1:0] run_len_q, run_len_d;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic [TAP_W-1:0] best_len_q, best_len_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic [TAP_W-1:0] eye_start_q, eye_start_d;
    logic [TAP_W-1:0] eye_width_q, eye_width_d;

    logic [TAP_W-1:0] ext_start, ext_len, target_c;
    logic             oor_now;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            step_q       <= '0;
            pass_q       <= 1'b0;
            oor_q        <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            tap_q        <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            target_q     <= '0;
            eye_start_q  <= '0;
            eye_width_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            pass_q       <= pass_d;
            oor_q        <= oor_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            tap_q        <= tap_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            target_q     <= target_d;
            eye_start_q  <= eye_start_d;
            eye_width_q  <= eye_width_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_d       = step_q;
        pass_d       = pass_q;
        oor_d        = oor_q;
        done_d       = done_q;
        fail_d       = fail_q;
        tap_d        = tap_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        target_d     = target_q;
        eye_start_d  = eye_start_q;
        eye_width_d  = eye_width_q;
        bus.delay_line_dir  = 1'b0;
        bus.delay_line_move = 1'b0;
        bus.delay_line_load = 1'b0;

        // Current run as it would stand if this tap's verdict were folded in.
        ext_start = run_start_q;
        ext_len   = run_len_q;
        if (pass_q) begin
            ext_len = (run_len_q == '1) ? run_len_q : run_len_q + TAP_W'(1);
            if (run_len_q == '0) ext_start = tap_q;
        end
        target_c = best_start_q + (best_len_q >> 1);
        // Range errors seen anywhere in the sweep are latched until the tap is judged.
        oor_now  = oor_q | bus.delay_line_out_of_range;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.delay_line_load = 1'b1;
                tap_d        = '0;
                cnt_d        = '0;
                run_start_d  = '0;
                run_len_d    = '0;
                best_start_d = '0;
                best_len_d   = '0;
                oor_d        = bus.delay_line_out_of_range;
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                oor_d = oor_now;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    pass_d  = 1'b1;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                oor_d  = oor_now;
                pass_d = pass_q & bus.eye_ok;
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EVAL: begin
                oor_d  = oor_now;
                step_d = '0;
                if (!pass_q || tap_q == LAST_TAP || oor_now) begin
                    // Strictly-longer replacement keeps the lowest start on ties.
                    if (ext_len > best_len_q) begin
                        best_len_d   = ext_len;
                        best_start_d = ext_start;
                    end
                    run_len_d = '0;
                end else begin
                    run_len_d   = ext_len;
                    run_start_d = ext_start;
                end
                state_d = (tap_q == LAST_TAP || oor_now) ? S_DECIDE : S_STEP_UP;
            end
            S_STEP_UP: begin
                oor_d               = oor_now;
                bus.delay_line_dir  = 1'b1;
                bus.delay_line_move = (step_q == 2'd1);
                if (step_q == 2'd1 && tap_q != LAST_TAP) tap_d = tap_q + TAP_W'(1);
                if (step_q == 2'd2) begin
                    step_d  = '0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            S_DECIDE: begin
                eye_start_d = best_start_q;
                eye_width_d = best_len_q;
                target_d    = target_c;
                step_d      = '0;
                if (best_len_q < MIN_W) begin
                    fail_d  = 1'b1;
                    state_d = S_FAIL;
                end else if (tap_q == target_c) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_STEP_DN;
                end
            end
            S_STEP_DN: begin
                bus.delay_line_move = (step_q == 2'd1);
                if (bus.delay_line_out_of_range) begin
                    fail_d  = 1'b1;
                    state_d = S_FAIL;
                end else begin
                    if (step_q == 2'd1 && tap_q != '0) tap_d = tap_q - TAP_W'(1);
                    if (step_q == 2'd2) begin
                        step_d = '0;
                        if (tap_q == target_q) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.tap_val   = tap_q;
    assign bus.eye_start = eye_start_q;
    assign bus.eye_width = eye_width_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_iod_clk_delay_train_ctrl.sv
// Directed scenarios for the delay-line trainer with hand-computed results.
module tb_iod_clk_delay_train_ctrl;
    localparam int TAP_W = 8;

    logic       clk;
    logic       rst;
    logic [3:0] dbg_state;

    iod_clk_delay_train_ctrl_if #(.TAP_W(TAP_W)) bus();

    iod_clk_delay_train_ctrl #(
        .NUM_TAPS(128), .TAP_W(TAP_W), .SETTLE_CYCLES(16), .SAMPLE_CYCLES(32), .MIN_EYE(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus.slave),
        .dbg_state_o(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Delay-line/eye model configuration, read by the model process.
    logic [127:0] pass_map  = '0;
    bit           glitch_en = 1'b0;
    int           oor_tap   = -1;
    bit           oor_force = 1'b0;

    // Model/monitor statistics, written only by the model process.
    int up_cnt   = 0;
    int dn_cnt   = 0;
    int load_cnt = 0;
    int viol_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Eye/range model plus protocol monitor, updated on the falling edge.
    initial begin : model
        logic [TAP_W-1:0] prev_tap;
        logic             prev_dir;
        int               settle_cnt;
        prev_tap   = '0;
        prev_dir   = 1'b0;
        settle_cnt = 0;
        bus.eye_ok = 1'b0;
        bus.delay_line_out_of_range = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tap_val != prev_tap) settle_cnt = 0;
            else if (settle_cnt < 1000) settle_cnt++;
            prev_tap = bus.tap_val;
            bus.eye_ok = pass_map[bus.tap_val] &&
                         !(glitch_en && bus.tap_val == 8'd30 && settle_cnt == 30);
            bus.delay_line_out_of_range = oor_force ||
                (oor_tap >= 0 && int'(bus.tap_val) == oor_tap && settle_cnt == 5);
            if (bus.delay_line_move && bus.delay_line_dir) up_cnt++;
            if (bus.delay_line_move && !bus.delay_line_dir) dn_cnt++;
            if (bus.delay_line_load) load_cnt++;
            if (bus.delay_line_move && bus.delay_line_load) viol_cnt++;
            if (bus.delay_line_move && bus.delay_line_dir != prev_dir) viol_cnt++;
            prev_dir = bus.delay_line_dir;
        end
    end

    task automatic set_window(input int lo, input int hi);
        pass_map = '0;
        for (int t = lo; t <= hi && t < 128; t++) pass_map[t] = 1'b1;
    endtask

    // Pulses START, optionally pokes a stray START at a given tap, waits for DONE/FAIL.
    task automatic start_and_wait(input int stray_tap, output bit finished, output bit load_seen,
                                  output int ups, output int dns, output int loads,
                                  output int viols);
        int  up0, dn0, ld0, vi0;
        bit  stray_done;
        up0 = up_cnt; dn0 = dn_cnt; ld0 = load_cnt; vi0 = viol_cnt;
        stray_done = 1'b0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        load_seen = bus.delay_line_load && bus.busy;
        finished  = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done || bus.fail) begin
                finished = 1'b1;
                break;
            end
            if (!stray_done && stray_tap >= 0 && int'(bus.tap_val) == stray_tap) begin
                bus.start  = 1'b1;
                stray_done = 1'b1;
            end
        end
        if (!finished) $display("timeout waiting for completion, state=%0d", dbg_state);
        ups = up_cnt - up0; dns = dn_cnt - dn0; loads = load_cnt - ld0; viols = viol_cnt - vi0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.fail, bus.delay_line_dir, bus.delay_line_move,
             bus.delay_line_load} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000", {bus.busy, bus.done, bus.fail,
                     bus.delay_line_dir, bus.delay_line_move, bus.delay_line_load});
        end
        n_checks++;
        if ({bus.tap_val, bus.eye_start, bus.eye_width} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_values: tap=%0d start=%0d width=%0d want 0/0/0",
                     bus.tap_val, bus.eye_start, bus.eye_width);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.delay_line_load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b load=%b want 0/0", bus.busy, bus.delay_line_load);
        end
    endtask

    task automatic test_wide_eye();
        bit fin, ld; int ups, dns, lds, vio;
        set_window(20, 59);
        start_and_wait(-1, fin, ld, ups, dns, lds, vio);
        n_checks++;
        if (!fin || ld !== 1'b1) begin
            n_fail++; $display("FAIL wide_run: finished=%b load_next=%b want 1/1", fin, ld);
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.fail !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_flags: done=%b fail=%b busy=%b want 1/0/0", bus.done, bus.fail, bus.busy);
        end
        n_checks++;
        if (bus.eye_start !== 8'd20 || bus.eye_width !== 8'd40 || bus.tap_val !== 8'd40) begin
            n_fail++;
            $display("FAIL wide_eye: start=%0d width=%0d tap=%0d want 20/40/40",
                     bus.eye_start, bus.eye_width, bus.tap_val);
        end
        n_checks++;
        if (ups != 127 || dns != 87 || vio != 0) begin
            n_fail++; $display("FAIL wide_moves: up=%0d dn=%0d viol=%0d want 127/87/0", ups, dns, vio);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL wide_hold: done=%b busy=%b want 1/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_no_eye();
        bit fin, ld; int ups, dns, lds, vio;
        set_window(200, 200);
        start_and_wait(-1, fin, ld, ups, dns, lds, vio);
        n_checks++;
        if (!fin || bus.fail !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL noeye_flags: fin=%b fail=%b done=%b busy=%b want 1/1/0/0",
                     fin, bus.fail, bus.done, bus.busy);
        end
        n_checks++;
        if (bus.eye_width !== 8'd0 || bus.tap_val !== 8'd127 || ups != 127 || dns != 0) begin
            n_fail++;
            $display("FAIL noeye_result: width=%0d tap=%0d up=%0d dn=%0d want 0/127/127/0",
                     bus.eye_width, bus.tap_val, ups, dns);
        end
    endtask

    task automatic test_tie();
        bit fin, ld; int ups, dns, lds, vio;
        set_window(10, 14);
        for (int t = 30; t <= 34; t++) pass_map[t] = 1'b1;
        start_and_wait(-1, fin, ld, ups, dns, lds, vio);
        n_checks++;
        if (!fin || bus.done !== 1'b1 || bus.fail !== 1'b0) begin
            n_fail++; $display("FAIL tie_flags: fin=%b done=%b fail=%b want 1/1/0", fin, bus.done, bus.fail);
        end
        n_checks++;
        if (bus.eye_start !== 8'd10 || bus.eye_width !== 8'd5 || bus.tap_val !== 8'd12) begin
            n_fail++;
            $display("FAIL tie_eye: start=%0d width=%0d tap=%0d want 10/5/12",
                     bus.eye_start, bus.eye_width, bus.tap_val);
        end
    endtask

    task automatic test_out_of_range();
        bit fin, ld; int ups, dns, lds, vio;
        set_window(40, 127);
        oor_tap = 50;
        start_and_wait(-1, fin, ld, ups, dns, lds, vio);
        oor_tap = -1;
        n_checks++;
        if (!fin || bus.done !== 1'b1 || ups != 50 || dns != 5) begin
            n_fail++;
            $display("FAIL oor_sweep: fin=%b done=%b up=%0d dn=%0d want 1/1/50/5", fin, bus.done, ups, dns);
        end
        n_checks++;
        if (bus.eye_start !== 8'd40 || bus.eye_width !== 8'd11 || bus.tap_val !== 8'd45) begin
            n_fail++;
            $display("FAIL oor_eye: start=%0d width=%0d tap=%0d want 40/11/45",
                     bus.eye_start, bus.eye_width, bus.tap_val);
        end
    endtask

    task automatic test_oor_at_load();
        bit fin, ld; int ups, dns, lds, vio;
        set_window(0, 127);
        oor_force = 1'b1;
        repeat (2) @(negedge clk);
        fork
            start_and_wait(-1, fin, ld, ups, dns, lds, vio);
            begin
                repeat (6) @(negedge clk);
                oor_force = 1'b0;
            end
        join
        n_checks++;
        if (!fin || bus.fail !== 1'b1 || bus.done !== 1'b0 || ups != 0) begin
            n_fail++;
            $display("FAIL oorload_flags: fin=%b fail=%b done=%b up=%0d want 1/1/0/0",
                     fin, bus.fail, bus.done, ups);
        end
        n_checks++;
        if (bus.eye_width !== 8'd1 || bus.eye_start !== 8'd0 || bus.tap_val !== 8'd0) begin
            n_fail++;
            $display("FAIL oorload_eye: width=%0d start=%0d tap=%0d want 1/0/0",
                     bus.eye_width, bus.eye_start, bus.tap_val);
        end
    endtask

    task automatic test_glitch();
        bit fin, ld; int ups, dns, lds, vio;
        set_window(20, 59);
        glitch_en = 1'b1;
        start_and_wait(-1, fin, ld, ups, dns, lds, vio);
        glitch_en = 1'b0;
        n_checks++;
        if (!fin || bus.done !== 1'b1) begin
            n_fail++; $display("FAIL glitch_flags: fin=%b done=%b want 1/1", fin, bus.done);
        end
        n_checks++;
        if (bus.eye_start !== 8'd31 || bus.eye_width !== 8'd29 || bus.tap_val !== 8'd45) begin
            n_fail++;
            $display("FAIL glitch_eye: start=%0d width=%0d tap=%0d want 31/29/45",
                     bus.eye_start, bus.eye_width, bus.tap_val);
        end
    endtask

    task automatic test_back_to_back();
        bit fin, ld, reached; int ups, dns, lds, vio;
        set_window(20, 59);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (bus.tap_val == 8'd70) begin
                reached = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (!reached || {bus.busy, bus.done, bus.fail, bus.delay_line_dir, bus.delay_line_move,
                         bus.delay_line_load} !== 6'b0) begin
            n_fail++;
            $display("FAIL midreset_flags: reached=%b flags=%b want 1/000000", reached,
                     {bus.busy, bus.done, bus.fail, bus.delay_line_dir, bus.delay_line_move,
                      bus.delay_line_load});
        end
        n_checks++;
        if ({bus.tap_val, bus.eye_start, bus.eye_width} !== 24'h0) begin
            n_fail++;
            $display("FAIL midreset_values: tap=%0d start=%0d width=%0d want 0/0/0",
                     bus.tap_val, bus.eye_start, bus.eye_width);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_and_wait(10, fin, ld, ups, dns, lds, vio);
        n_checks++;
        if (!fin || ld !== 1'b1 || lds != 1) begin
            n_fail++; $display("FAIL b2b_load: fin=%b load_next=%b loads=%0d want 1/1/1", fin, ld, lds);
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.eye_start !== 8'd20 || bus.eye_width !== 8'd40 ||
            bus.tap_val !== 8'd40) begin
            n_fail++;
            $display("FAIL b2b_eye: done=%b start=%0d width=%0d tap=%0d want 1/20/40/40",
                     bus.done, bus.eye_start, bus.eye_width, bus.tap_val);
        end
        n_checks++;
        if (ups != 127 || dns != 87 || vio != 0) begin
            n_fail++; $display("FAIL b2b_moves: up=%0d dn=%0d viol=%0d want 127/87/0", ups, dns, vio);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        test_reset();
        test_wide_eye();
        test_no_eye();
        test_tie();
        test_out_of_range();
        test_oor_at_load();
        test_glitch();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
